// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if
// Groups the EXE-stage signals between the pipeline and the multiply/divide
// unit.
//   master : pipeline side. Drives the start/op/operands and the MTHI/MTLO
//            strobes, and reads busy/done/hi/lo.
//   slave  : multiply/divide unit side.
// Signals:
//   estart     mul/div instruction in EXE (held while stalled)
//   eop[1:0]   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   ea, eb     rs / rt operands (ea also carries MTHI/MTLO data)
//   ewhi/ewlo  MTHI / MTLO strobes
//   busy       stall request
//   done       one-cycle completion pulse
//   hi, lo     architectural HI/LO registers
interface exe_muldiv_if;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        ewhi;
  logic        ewlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output estart, eop, ea, eb, ewhi, ewlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  estart, eop, ea, eb, ewhi, ewlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/exe_muldiv.sv
// exe_muldiv
// Iterative 32-bit multiply/divide unit in the EXE stage. It owns the HI/LO
// registers.
// MULT/MULTU use shift-add, and DIV/DIVU use restoring division. Each runs
// one bit per cycle for 32 cycles. The unit stalls the pipeline through
// busy while it runs. It also services MTHI/MTLO when it is idle.
// Ports:
//   clk   pipeline clock, rising edge
//   clrn  asynchronous active-low reset
//   bus   exe_muldiv_if.slave (estart, eop, ea, eb, ewhi, ewlo -> busy,
//         done, hi, lo)
module exe_muldiv (
  input  logic         clk,
  input  logic         clrn,
  exe_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  // The multiply holds {partial product, remaining multiplier bits} in acc.
  // The divide holds {partial remainder, dividend bits / quotient bits} in acc.
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        op_div;
  logic        neg_a;
  logic        neg_b;
  logic        div0;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_signed;
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        ge;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Operand preparation at issue. Signed ops iterate on magnitudes, and the
  // signs are applied again at the end.
  assign is_signed = ~bus.eop[0];
  assign in_neg_a  = is_signed & bus.ea[31];
  assign in_neg_b  = is_signed & bus.eb[31];
  assign abs_a     = in_neg_a ? (32'd0 - bus.ea) : bus.ea;
  assign abs_b     = in_neg_b ? (32'd0 - bus.eb) : bus.eb;

  // One iteration of either algorithm.
  // The divide's trial subtract is 33 bits wide. A set bit 32 in the shifted
  // remainder already means it exceeds any 32-bit divisor.
  // A zero divisor produces an all-ones quotient. The remainder then ends up
  // equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    rem_shift = {acc[63:32], acc[31]};
    trial     = rem_shift - {1'b0, opnd};
    ge        = rem_shift[32] | ~trial[32];
    if (op_div) begin
      if (ge) acc_step = {trial[31:0], acc[30:0], 1'b1};
      else    acc_step = {rem_shift[31:0], acc[30:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[31:1]};
    end
  end

  // Sign correction of the final iteration's result.
  // The remainder takes the dividend sign, which also restores a negative
  // dividend in the divide-by-zero case.
  always_comb begin
    prod   = (neg_a ^ neg_b) ? (64'd0 - acc_step) : acc_step;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_div) begin
      res_hi = neg_a ? (32'd0 - acc_step[63:32]) : acc_step[63:32];
      res_lo = ((neg_a ^ neg_b) & ~div0) ? (32'd0 - acc_step[31:0]) : acc_step[31:0];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_next;
  end

  // DONE ignores estart because the finishing instruction is still in EXE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.estart) state_next = RUN;
      RUN:     if (cnt == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO.
  // MTHI/MTLO are accepted only in IDLE without a start, so that estart
  // takes priority.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      op_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div0   <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.estart) begin
            op_div <= bus.eop[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            div0   <= bus.eop[1] & (bus.eb == 32'd0);
            cnt    <= 5'd0;
            acc    <= {32'd0, (bus.eop[1] ? abs_a : abs_b)};
            opnd   <= bus.eop[1] ? abs_b : abs_a;
          end else begin
            if (bus.ewhi) hi_r <= bus.ea;
            if (bus.ewlo) lo_r <= bus.ea;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue cycle is stalled as well.
  // Reset forces busy low even if estart is high.
  assign bus.busy = clrn & ((state == RUN) | ((state == IDLE) & bus.estart));
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv
// Scoreboard bench for exe_muldiv.
// The stimulus side pushes the hand-computed HI/LO results and the cycle in
// which done is due. A separate monitor pops one entry and checks it on
// every done pulse.
module tb_exe_muldiv;

  logic clk = 1'b0;
  logic clrn;
  int   cyc = 0;

  exe_muldiv_if bus();

  exe_muldiv dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle index used to check done latency.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors       = 0;
  int   miscompares   = 0;
  int   doneSeen      = 0;
  int   donesExpected = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (clrn === 1'b1 && bus.done === 1'b1) begin
      doneSeen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected done at cycle %0d: got done=1, expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, " hi"}, bus.hi, e.hi);
        checkOutput({e.name, " lo"}, bus.lo, e.lo);
        checkOutput({e.name, " done cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issues an op in the next cycle. The op's done is due 33 cycles later.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input string name, input bit track);
    exp_t e;
    @(posedge clk);
    #1;
    bus.estart = 1'b1;
    bus.eop    = op;
    bus.ea     = a;
    bus.eb     = b;
    if (track) begin
      e.hi   = expHi;
      e.lo   = expLo;
      e.due  = cyc + 33;
      e.name = name;
      sb.push_back(e);
      donesExpected++;
    end
  endtask

  // Bounded wait for done. Counts the busy cycles seen on the way.
  task automatic waitDone(input string name, input int expBusy);
    int busyCycles = 0;
    bit seen       = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo, input string name);
    applyStimulus(op, a, b, expHi, expLo, name, 1'b1);
    waitDone(name, 33);
  endtask

  task automatic goIdle();
    @(posedge clk);
    #1;
    bus.estart = 1'b0;
    bus.ewhi   = 1'b0;
    bus.ewlo   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clrn       = 1'b0;
    bus.estart = 1'b1;
    bus.eop    = 2'b00;
    bus.ea     = 32'd0;
    bus.eb     = 32'd0;
    bus.ewhi   = 1'b0;
    bus.ewlo   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", bus.hi, 32'h0);
    checkOutput("reset lo", bus.lo, 32'h0);
    checkOutput("reset busy forced low", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    clrn       = 1'b1;
    bus.estart = 1'b0;

    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max");
    goIdle();
    runOp(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3x5");
    goIdle();
    runOp(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    goIdle();
    runOp(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2");
    goIdle();
    runOp(2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu by zero");
    goIdle();
    runOp(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div neg by zero");
    goIdle();
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div overflow");
    goIdle();
    runOp(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult minint sq");
    goIdle();
    runOp(2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu max/16");
    goIdle();

    // estart stays high through DONE, and the next MULT enters in the
    // following IDLE cycle.
    runOp(2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, "b2b first");
    runOp(2'b00, 32'h00012345, 32'h00000100, 32'h00000000, 32'h01234500, "b2b second");
    goIdle();

    // MTHI then MTLO while idle.
    @(posedge clk);
    #1;
    bus.ewhi = 1'b1;
    bus.ea   = 32'h12345678;
    @(negedge clk);
    checkOutput("mthi busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.ewhi = 1'b0;
    bus.ewlo = 1'b1;
    bus.ea   = 32'h9ABCDEF0;
    checkOutput("mthi hi", bus.hi, 32'h12345678);
    @(negedge clk);
    checkOutput("mtlo busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.ewlo = 1'b0;
    checkOutput("mtlo lo", bus.lo, 32'h9ABCDEF0);
    checkOutput("mtlo keeps hi", bus.hi, 32'h12345678);

    // An MTHI strobe alongside estart must be dropped.
    applyStimulus(2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, "multu 3x4", 1'b1);
    bus.ewhi = 1'b1;
    @(posedge clk);
    #1;
    bus.ewhi = 1'b0;
    checkOutput("mthi dropped on start", bus.hi, 32'h12345678);
    waitDone("multu 3x4", 32);
    goIdle();

    // Reset during a DIV aborts it.
    applyStimulus(2'b10, 32'h000003E8, 32'h00000007, 32'h0, 32'h0, "aborted div", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    clrn       = 1'b0;
    bus.estart = 1'b0;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort hi", bus.hi, 32'h0);
    checkOutput("abort lo", bus.lo, 32'h0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(negedge clk);
    checkOutput("post-reset idle busy", 32'(bus.busy), 32'd0);
    runOp(2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, "multu 6x7");
    goIdle();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    checkOutput("done pulse count", 32'(doneSeen), 32'(donesExpected));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage of the five-stage pipeline, fed from the ID/EXE pipeline register outputs (`ea`, `eb`, decoded op) and owning the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU in 32 iterations, one bit per cycle. While it runs it drives `busy` back to the pipeline control, which freezes PC, IF/ID and ID/EXE so the issuing instruction stays in EXE. It also services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO.

## Interface
Parameters: none (data width fixed at 32, iteration count fixed at 32).
- `clk`  in  1  pipeline clock, rising edge
- `clrn`  in  1  asynchronous active-low reset
- `estart`  in  1  EXE instruction is MULT/MULTU/DIV/DIVU; held high while stalled
- `eop`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with `estart`
- `ea`  in  32  rs operand / dividend / MTHI-MTLO data
- `eb`  in  32  rt operand / divisor
- `ewhi`  in  1  MTHI in EXE: HI <= `ea`
- `ewlo`  in  1  MTLO in EXE: LO <= `ea`
- `busy`  out  1  stall request to pipeline control
- `done`  out  1  one-cycle pulse, HI/LO hold the new result
- `hi`  out  32  HI register (registered)
- `lo`  out  32  LO register (registered)

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN, DONE; 5-bit iteration counter `cnt`.
- IDLE: on `estart`, latch |ea|, |eb| (absolute values for MULT/DIV, raw for MULTU/DIVU), sign flags, op; `cnt` <= 0; go RUN.
- RUN, multiply: 64-bit accumulator, shift-add one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle; 33-bit trial subtract.
- RUN exits after `cnt` == 31, i.e. 32 RUN cycles, then goes DONE.
- On the RUN->DONE edge, HI/LO are written with the sign-corrected result:
  - MULT: 64-bit product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend sign.
  - MULTU/DIVU: no correction.
- DIV/DIVU with `eb` == 0: HI <= raw `ea`, LO <= 32'hFFFFFFFF, no sign correction; same latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural result, no trap).
- DONE: `done`=1, `busy`=0; `estart` is ignored because the same instruction is still in EXE; next state IDLE.
- `busy` = (state==RUN) | (state==IDLE & `estart`), combinational. The issue cycle is stalled.
- `ewhi`/`ewlo` take effect only in IDLE with `estart`=0. If `estart` is also high, `estart` wins and the write is dropped. Writes are ignored in RUN and DONE (cannot occur; pipeline is stalled).
- HI/LO are unchanged except by a completed operation or MTHI/MTLO.

## Timing
- Reset (`clrn`=0, any state): state IDLE, `cnt`=0, `hi`=0, `lo`=0, `done`=0. `busy` forced 0 while `clrn`=0. Internal datapath registers cleared.
- Reset mid-operation aborts; HI/LO read 0 afterward, not a partial result.
- Cycle 0: issue edge, IDLE with `estart`, `busy`=1.
- Cycles 1-32: RUN, `busy`=1.
- Cycle 33: DONE, `busy`=0, `done`=1, `hi`/`lo` valid.
- Instruction occupancy of EXE: 34 cycles.
- Back-to-back: a mul/div instruction entering EXE in the cycle after DONE is accepted in that IDLE cycle. No lost or duplicate starts.
- MFHI/MFLO in ID during DONE reads the new value (registered outputs updated at the start of DONE).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `busy` high cycles 0-32; cycle 33 `done`=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x64 / 0 -> HI=0x00000064, LO=0xFFFFFFFF at cycle 33. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- `estart` held high through DONE, then a second MULT issued in the next IDLE cycle -> exactly two `done` pulses, 34 cycles apart; second result correct.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 in IDLE -> `hi`/`lo` update next edge, `busy` stays 0. `ewhi` with `estart` in the same cycle -> write dropped, operation starts.
- `clrn` pulsed low at cycle 10 of a DIV -> `busy`=0 immediately, HI=LO=0, state IDLE. A subsequent MULTU 6×7 completes with LO=42, HI=0 at cycle 33.
